pipeline_ctrl: RTL
==================

# pipeline_ctrl

Pipeline sequencing controller for the five-stage MIPS core. It owns the PC write enable, the IF/ID hold and flush controls, ID/EX bubble insertion and the next-PC select. From these it sequences start-up, load-use stalls, taken-branch/jump flushes and a controlled drain-to-halt. It sits beside the ID stage, taking hazard inputs from IF/ID and ID/EX and driving the PC mux, the PC, and the stage-latch enables and resets.

## Interface
- `REG_W`, 5, register-address width
- `STALL_CYC`, 1, bubbles inserted per load-use hazard (≥1)
- `PERF_W`, 16, performance-counter width
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-low
- `start`  in  1  level; leaves IDLE/HALT when sampled high
- `halt_req`  in  1  level; request drain and halt
- `idex_mem_read`  in  1  ID/EX instruction is a load
- `idex_rt`  in  REG_W  load destination in ID/EX
- `ifid_rs`  in  REG_W  ID-stage source 1
- `ifid_rt`  in  REG_W  ID-stage source 2
- `ifid_uses_rt`  in  1  ID instruction reads rt as a source
- `branch_taken`  in  1  branch resolved taken in ID
- `jump`  in  1  jump decoded in ID
- `pc_we`  out  1  PC write enable
- `pc_sel`  out  2  00 = PC+4, 10 = jump target, 11 = branch target; 01 is never driven
- `ifid_en`  out  1  IF/ID latch enable
- `ifid_flush`  out  1  IF/ID synchronous clear
- `idex_flush`  out  1  ID/EX control latches clear (bubble)
- `running`  out  1  state is RUN or STALL
- `stall_count`, `flush_count`  out  PERF_W  (only with macro)

## Operation
- States: IDLE, RUN, STALL, DRAIN, HALT. Reset state is IDLE.
- Load-use hazard (`hz`): `idex_mem_read` && `idex_rt`≠0 && (`idex_rt`==`ifid_rs` || (`ifid_uses_rt` && `idex_rt`==`ifid_rt`)).
- IDLE: pc_we=0, ifid_en=0, idex_flush=1. Goes to RUN when `start`=1.
- RUN, priority halt_req > hz > jump > branch_taken:
  - `halt_req`: go to DRAIN, drain counter=0.
  - `hz`: pc_we=0, ifid_en=0, idex_flush=1. If STALL_CYC>1, go to STALL with counter=STALL_CYC-1.
  - `jump`: pc_sel=10 and ifid_flush=1.
  - `branch_taken`: pc_sel=11 and ifid_flush=1.
  - Otherwise: pc_we=1, ifid_en=1, pc_sel=00.
- STALL: same outputs as a `hz` cycle. The counter decrements each cycle. Returns to RUN after the cycle in which the counter is 1. `halt_req` moves to DRAIN immediately.
- DRAIN: pc_we=0, ifid_flush=1, idex_flush=1 for 4 cycles (ID, EX, MEM, WB empty), then HALT.
- HALT: same outputs as IDLE. `start`=1 returns to RUN; the PC is untouched, so execution resumes at the held PC.
- `start` is ignored in RUN, STALL and DRAIN. `halt_req` is ignored outside RUN and STALL.

## Timing
- Control outputs are combinational from the current state plus the hazard, branch and jump inputs; they take effect at the next clk edge.
- State and counters are registered.
- Reset (asynchronous, any state, mid-stall or mid-drain) forces:
  - state IDLE, counters 0;
  - pc_we=0, pc_sel=00, ifid_en=0, ifid_flush=0, idex_flush=1, running=0.
- Load-use penalty is exactly STALL_CYC cycles. Branch/jump penalty is exactly 1 flushed slot.
- `hz` together with `jump`/`branch_taken` in the same cycle: the stall wins, and the redirect is taken on the first post-stall RUN cycle.

## Configuration
- `PIPE_CTRL_PERF_EN` defined:
  - `stall_count` increments once per cycle with idex_flush=1 due to hz or STALL.
  - `flush_count` increments once per redirect.
  - Both saturate at all-ones and are cleared by reset.
- Not defined: both ports and counters are absent.

## Structure
- Package `pipe_ctrl_pkg` holds:
  - the state enum;
  - PC_SEL_INC/JUMP/BRANCH encodings;
  - DRAIN_CYC=4.
- Sub-module `load_use_detect` is the purely combinational `hz` comparator, reused later by the forwarding unit.

## Test plan
- Load r2 in ID/EX, `ifid_rs`=2, STALL_CYC=1 -> one cycle pc_we=0, ifid_en=0, idex_flush=1, then RUN with pc_we=1; stall_count=1.
- `idex_rt`=0 with a matching `ifid_rs`=0 -> no stall, pc_we=1.
- `branch_taken`=1 -> pc_sel=11, ifid_flush=1 for one cycle; same cycle with `hz` -> stall first, pc_sel=11 next cycle.
- STALL_CYC=3 with `halt_req` raised in the 2nd stall cycle -> DRAIN next cycle, 4 drain cycles, HALT, running=0; `start` -> RUN.
- Reset asserted mid-DRAIN -> immediately IDLE, idex_flush=1, pc_we=0; counters 0 after release.
- Macro on: 65 535+ stall cycles with PERF_W=16 -> `stall_count` holds at 16'hFFFF.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
package pipe_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RUN   = 3'd1,
      S_STALL = 3'd2,
      S_DRAIN = 3'd3,
      S_HALT  = 3'd4
   } pipe_state_e;

   // Next-PC mux select; 2'b01 is never produced.
   localparam logic [1:0] PC_SEL_INC    = 2'b00;
   localparam logic [1:0] PC_SEL_JUMP   = 2'b10;
   localparam logic [1:0] PC_SEL_BRANCH = 2'b11;

   localparam int DRAIN_CYC = 4;
   localparam int DRAIN_W   = $clog2(DRAIN_CYC);

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs and stage-control outputs of the pipeline controller.
// Optional perf counters exist only when PIPE_CTRL_PERF_EN is defined.
interface pipeline_ctrl_if #(
   parameter int REG_W  = 5,
   parameter int PERF_W = 16
);
   // All signals are plain levels with no valid/ready handshake: the pipeline
   // presents hazard/redirect levels each cycle, the controller answers
   // combinationally and its decisions take effect at the next clk edge.
   logic             start;
   logic             halt_req;
   logic             idex_mem_read;
   logic [REG_W-1:0] idex_rt;
   logic [REG_W-1:0] ifid_rs;
   logic [REG_W-1:0] ifid_rt;
   logic             ifid_uses_rt;
   logic             branch_taken;
   logic             jump;
   logic             pc_we;
   logic [1:0]       pc_sel;
   logic             ifid_en;
   logic             ifid_flush;
   logic             idex_flush;
   logic             running;
`ifdef PIPE_CTRL_PERF_EN
   logic [PERF_W-1:0] stall_count;
   logic [PERF_W-1:0] flush_count;
`endif

   modport master (
      input  start, halt_req, idex_mem_read, idex_rt, ifid_rs, ifid_rt,
             ifid_uses_rt, branch_taken, jump,
      output pc_we, pc_sel, ifid_en, ifid_flush, idex_flush, running
`ifdef PIPE_CTRL_PERF_EN
      , output stall_count, flush_count
`endif
   );

   modport slave (
      output start, halt_req, idex_mem_read, idex_rt, ifid_rs, ifid_rt,
             ifid_uses_rt, branch_taken, jump,
      input  pc_we, pc_sel, ifid_en, ifid_flush, idex_flush, running
`ifdef PIPE_CTRL_PERF_EN
      , input stall_count, flush_count
`endif
   );

endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use hazard comparator between ID/EX and IF/ID.
module load_use_detect #(
   parameter int REG_W = 5
) (
   input  logic             mem_read,
   input  logic [REG_W-1:0] ex_rt,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_uses_rt,
   output logic             hz
);

   // r0 is hardwired zero, so a load targeting it never creates a dependency.
   assign hz = mem_read && (ex_rt != '0) &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline sequencer: start-up, load-use stalls, redirects, drain-to-halt.
// Define PIPE_CTRL_PERF_EN to add saturating stall/flush performance counters.
module pipeline_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_W     = 5,
   parameter int STALL_CYC = 1,
   parameter int PERF_W    = 16
) (
   input  logic        clk,
   input  logic        rst,
   pipeline_ctrl_if.master bus,
   output pipe_state_e state_o
);

   localparam int CNT_W = (STALL_CYC > 1) ? $clog2(STALL_CYC) : 1;

   generate
      if (STALL_CYC < 1 || PERF_W < 1) begin : g_bad_cfg
         $error("pipeline_ctrl: STALL_CYC and PERF_W must be at least 1");
      end
   endgenerate

   pipe_state_e        state_q, state_d;
   logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
   logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
   logic               hz;

   load_use_detect #(.REG_W(REG_W)) u_hz (
      .mem_read   (bus.idex_mem_read),
      .ex_rt      (bus.idex_rt),
      .id_rs      (bus.ifid_rs),
      .id_rt      (bus.ifid_rt),
      .id_uses_rt (bus.ifid_uses_rt),
      .hz         (hz)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         stall_cnt_q <= '0;
         drain_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         stall_cnt_q <= stall_cnt_d;
         drain_cnt_q <= drain_cnt_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      stall_cnt_d    = stall_cnt_q;
      drain_cnt_d    = drain_cnt_q;
      bus.pc_we      = 1'b0;
      bus.pc_sel     = PC_SEL_INC;
      bus.ifid_en    = 1'b0;
      bus.ifid_flush = 1'b0;
      bus.idex_flush = 1'b0;
      unique case (state_q)
         S_IDLE, S_HALT: begin
            bus.idex_flush = 1'b1;
            if (bus.start) state_d = S_RUN;
         end
         S_RUN: begin
            if (bus.halt_req) begin
               state_d     = S_DRAIN;
               drain_cnt_d = '0;
            end else if (hz) begin
               // A concurrent redirect stays asserted by ID and is taken after the stall.
               bus.idex_flush = 1'b1;
               if (STALL_CYC > 1) begin
                  state_d     = S_STALL;
                  stall_cnt_d = CNT_W'(STALL_CYC - 1);
               end
            end else if (bus.jump) begin
               bus.pc_we      = 1'b1;
               bus.ifid_en    = 1'b1;
               bus.pc_sel     = PC_SEL_JUMP;
               bus.ifid_flush = 1'b1;
            end else if (bus.branch_taken) begin
               bus.pc_we      = 1'b1;
               bus.ifid_en    = 1'b1;
               bus.pc_sel     = PC_SEL_BRANCH;
               bus.ifid_flush = 1'b1;
            end else begin
               bus.pc_we   = 1'b1;
               bus.ifid_en = 1'b1;
            end
         end
         S_STALL: begin
            bus.idex_flush = 1'b1;
            stall_cnt_d    = stall_cnt_q - 1'b1;
            if (bus.halt_req) begin
               state_d     = S_DRAIN;
               drain_cnt_d = '0;
            end else if (stall_cnt_q == CNT_W'(1)) begin
               state_d = S_RUN;
            end
         end
         S_DRAIN: begin
            bus.ifid_flush = 1'b1;
            bus.idex_flush = 1'b1;
            if (drain_cnt_q == DRAIN_W'(DRAIN_CYC - 1)) state_d = S_HALT;
            else drain_cnt_d = drain_cnt_q + 1'b1;
         end
         default: begin
            state_d        = S_IDLE;
            bus.idex_flush = 1'b1;
         end
      endcase
   end

   assign bus.running = (state_q == S_RUN) || (state_q == S_STALL);
   assign state_o     = state_q;

`ifdef PIPE_CTRL_PERF_EN
   logic [PERF_W-1:0] stall_count_q, stall_count_d;
   logic [PERF_W-1:0] flush_count_q, flush_count_d;

   // While running, idex_flush only comes from a stall and ifid_flush only from a redirect.
   always_comb begin
      stall_count_d = stall_count_q;
      flush_count_d = flush_count_q;
      if (bus.running && bus.idex_flush && (stall_count_q != '1))
         stall_count_d = stall_count_q + 1'b1;
      if (bus.running && bus.ifid_flush && (flush_count_q != '1))
         flush_count_d = flush_count_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_count_q <= '0;
         flush_count_q <= '0;
      end else begin
         stall_count_q <= stall_count_d;
         flush_count_q <= flush_count_d;
      end
   end

   assign bus.stall_count = stall_count_q;
   assign bus.flush_count = flush_count_q;
`endif

endmodule
